// File: rtl/d_ff_tb.sv
// ============================================================================
// Module      : d_ff_tb
// Description : Edge-triggered D-type storage element with configurable width
//               and pipeline depth. d is sampled on the rising clock edge and
//               presented on q after STAGES edges. The reset is synchronous
//               and active-low, and it loads RESET_VALUE into every stage.
//               When the macro D_FF_TB_QBAR_EN is defined, the module also
//               provides a complementary output qn (= ~q), which is derived
//               from the last register with no extra state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_ff_tb #(
  parameter int WIDTH                   = 1,
  parameter int STAGES                  = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef D_FF_TB_QBAR_EN
  ,
  output logic [WIDTH-1:0] qn
`endif
);

  // Reject degenerate configurations at elaboration time.
  generate
    if ((WIDTH < 1) || (STAGES < 1)) begin : g_param_check
      $error("d_ff_tb: WIDTH and STAGES must both be >= 1");
    end
  endgenerate

  // Register chain. stage[0] takes d. stage[STAGES-1] drives q.
  logic [WIDTH-1:0] stage [STAGES];

  // Shift d through the chain; reset has priority and clears all in-flight data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= RESET_VALUE;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

`ifdef D_FF_TB_QBAR_EN
  // Complement comes straight off the output register, so it can never
  // disagree with q.
  assign qn = ~stage[STAGES-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_d_ff_tb.sv
// ============================================================================
// Module      : tb_d_ff_tb
// Description : Scoreboard bench for d_ff_tb. It contains two instances:
//               the default 1-bit, 1-stage flop, and an 8-bit, 3-stage
//               pipeline with RESET_VALUE 8'hA5. The stimulus tasks push
//               hand-computed expectations, tagged with the clock edge they
//               refer to. A monitor on the falling edge pops and compares
//               them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_ff_tb;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  val;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst1, d1, q1;
  logic       rst8;
  logic [7:0] d8, q8;
`ifdef D_FF_TB_QBAR_EN
  logic       qn1;
  logic [7:0] qn8;
`endif

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb1[$];
  exp_t        sb8[$];

  // Period 10, first rising edge at t=5.
  always #5 clk = ~clk;

  // Count rising edges so expectations can name the edge they belong to.
  always @(posedge clk) cyc <= cyc + 1;

  d_ff_tb u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .d     (d1),
`ifdef D_FF_TB_QBAR_EN
    .qn    (qn1),
`endif
    .q     (q1)
  );

  d_ff_tb #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hA5)) u_dut8 (
    .clk   (clk),
    .reset (rst8),
    .d     (d8),
`ifdef D_FF_TB_QBAR_EN
    .qn    (qn8),
`endif
    .q     (q8)
  );

  // Compare one value against its expectation and report any mismatch.
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: on each falling edge, retire every expectation that is due.
  always @(negedge clk) begin
    exp_t e;
    while (sb1.size() > 0 && sb1[0].cyc <= cyc) begin
      e = sb1.pop_front();
      check({e.name, " q"}, {7'b0, q1}, e.val);
`ifdef D_FF_TB_QBAR_EN
      check({e.name, " qn"}, {7'b0, qn1}, {7'b0, ~e.val[0]});
`endif
    end
    while (sb8.size() > 0 && sb8[0].cyc <= cyc) begin
      e = sb8.pop_front();
      check({e.name, " q"}, q8, e.val);
`ifdef D_FF_TB_QBAR_EN
      check({e.name, " qn"}, qn8, ~e.val);
`endif
    end
  end

  // Drive the 1-bit DUT mid-cycle.
  // Optionally check q at this falling edge (no async path) and after the next edge.
  task automatic step1(input logic r, input logic dv, input logic exp_next,
                       input string nm, input bit chk_now, input logic exp_now);
    exp_t e;
    @(posedge clk);
    #2;
    rst1 = r;
    d1   = dv;
    if (chk_now) begin
      e.cyc = cyc; e.val = {7'b0, exp_now}; e.name = {nm, "_hold"};
      sb1.push_back(e);
    end
    e.cyc = cyc + 1; e.val = {7'b0, exp_next}; e.name = nm;
    sb1.push_back(e);
  endtask

  // Drive the pipeline DUT mid-cycle and expect exp_next after the next edge.
  task automatic step8(input logic r, input logic [7:0] dv, input logic [7:0] exp_next,
                       input string nm);
    exp_t e;
    @(posedge clk);
    #2;
    rst8 = r;
    d8   = dv;
    e.cyc = cyc + 1; e.val = exp_next; e.name = nm;
    sb8.push_back(e);
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    rst1 = 1'b1; d1 = 1'b1;
    rst8 = 1'b1; d8 = 8'h3C;

    // 1. Reset entry, then hold reset with d toggling.
    step1(0, 1, 0, "rst_entry", 0, 0);
    step1(0, 0, 0, "rst_hold0", 0, 0);
    step1(0, 1, 0, "rst_hold1", 0, 0);
    step1(0, 0, 0, "rst_hold2", 0, 0);
    step1(0, 1, 0, "rst_hold3", 0, 0);
    step1(0, 0, 0, "rst_hold4", 0, 0);
    // 2. Capture.
    step1(1, 1, 1, "cap_one", 0, 0);
    step1(1, 0, 0, "cap_zero", 1, 1);
    // 3. Synchronous reset asserted and released mid-cycle.
    step1(1, 1, 1, "pre_sync", 0, 0);
    step1(0, 1, 0, "sync_rst", 1, 1);
    step1(1, 1, 1, "sync_rel", 1, 0);
    step1(1, 0, 0, "follow_d", 0, 0);
    // 4. Reset dominates d.
    step1(0, 1, 0, "dom_a", 0, 0);
    step1(0, 1, 0, "dom_b", 0, 0);
    step1(1, 1, 1, "dom_rel", 0, 0);

    // 5. Three-stage pipeline.
    step8(0, 8'h00, 8'hA5, "p_reset");
    step8(1, 8'h01, 8'hA5, "p_e1");
    step8(1, 8'h02, 8'hA5, "p_e2");
    step8(1, 8'h03, 8'h01, "p_e3");
    step8(1, 8'h04, 8'h02, "p_e4");
    step8(0, 8'h05, 8'hA5, "p_midrst");
    step8(1, 8'h06, 8'hA5, "p_r1");
    step8(1, 8'h07, 8'hA5, "p_r2");
    step8(1, 8'h08, 8'h06, "p_r3");
    step8(1, 8'h09, 8'h07, "p_r4");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && (sb1.size() > 0 || sb8.size() > 0); i++) @(negedge clk);
    #1;
    if (sb1.size() > 0 || sb8.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb1.size() + sb8.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: run still active at t=%0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
